seq_word_reader: RTL and testbench
==================================

Name: seq_word_reader

Overview:
- Reader end of the 288-bit random-sequence interface.
- Requests a sequence from the LFSR sequence generator and waits for its done flag.
- Captures the 288-bit word, then streams it MSB-first as nine 32-bit words to the hash input stage over a valid/ready handshake.
- Checks the 32-bit zero pad and flags any violation.

Parameters:
- SEQ_WIDTH, 288, width of the captured sequence (256 random bits + 32-bit pad).
- WORD_WIDTH, 32, width of each streamed word; SEQ_WIDTH must be an integer multiple.
- NUM_WORDS, SEQ_WIDTH/WORD_WIDTH = 9, words per sequence (derived, not overridden).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request one sequence transfer; sampled only in IDLE.
- gen_enable  output  1  enable to the sequence generator.
- random_sequence  input  288  sequence from the generator; valid only while done_creating_sequence=1.
- done_creating_sequence  input  1  generator done flag (level).
- word_out  output  32  current word, MSB-first slice of the captured sequence.
- word_valid  output  1  word_out is valid.
- word_ready  input  1  downstream accepts word_out this cycle.
- word_last  output  1  high with word_valid on the 9th word (pad word).
- busy  output  1  high in any state other than IDLE.
- seq_done  output  1  one-cycle pulse after the last word is accepted.
- pad_error  output  1  captured low 32 bits were nonzero; sticky until next capture or reset.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; shift register, word counter, gen_enable, word_out, word_valid, word_last, busy, seq_done and pad_error all 0.
  - Reset mid-transfer aborts immediately; no seq_done.
- States: IDLE, REQ, SEND, DONE.
- IDLE:
  - start=1 -> REQ on the next edge.
  - start is ignored in every other state (no queuing).
- REQ:
  - gen_enable=1.
  - On the first edge with done_creating_sequence=1:
    - shift_reg <= random_sequence.
    - pad_error <= (random_sequence[31:0] != 0).
    - count <= 0; -> SEND.
  - gen_enable drops in the same edge.
  - If done is already high on entry, capture occurs on the first REQ edge: minimum 1 cycle in REQ.
- SEND:
  - word_valid=1; word_out=shift_reg[287:256]; word_last=(count==8).
  - On an edge with word_valid & word_ready: shift_reg <= shift_reg << 32, count <= count+1.
  - If count was 8 -> DONE.
  - While word_ready=0, word_out, word_valid and word_last hold stable (no retraction).
  - Back-to-back acceptance: one word per cycle, so 9 cycles minimum in SEND.
- DONE:
  - seq_done=1 for exactly one cycle, word_valid=0 -> IDLE.
  - start high in DONE is ignored; it must be high again in IDLE.
- count is 4 bits and never exceeds 8; no wrap.
- Generator coupling:
  - The generator holds done and its output once finished and does not regenerate without its own reset.
  - A second start without an upstream generator reset re-reads the same sequence.
  - That is accepted behaviour; upstream sequencing owns generator reset.
- pad_error is updated only at capture, and is otherwise held.
- busy=1 in REQ, SEND and DONE.

Test Plan:
- Reset during SEND (after 3 accepts): reset=0 -> all outputs 0 asynchronously, state IDLE; after release, start gives a fresh REQ.
- Nominal transfer:
  - Stimulus: random_sequence={32'h11111111,...,32'h88888888,32'h00000000}, done high one cycle after gen_enable, word_ready=1.
  - Response: words 11111111..88888888 then 00000000 on consecutive cycles; word_last only on the 9th; seq_done pulse the cycle after; pad_error=0; total start->seq_done = 1 (IDLE->REQ) + 2 (REQ) + 9 + 1 cycles.
- Backpressure: word_ready toggles 1,0,0,1 repeating -> each word held stable while ready=0; exactly 9 accepts; no duplicated or skipped word (checked against the 11111111.. pattern).
- Pad violation: low 32 bits = 32'hDEADBEEF -> pad_error=1 from the capture cycle; word 9 = DEADBEEF with word_last; pad_error stays 1 through DONE/IDLE; the next clean capture clears it.
- Done pre-asserted and start ignored:
  - done_creating_sequence already 1 at start -> capture on the first REQ edge, gen_enable high exactly 1 cycle.
  - start pulsed during SEND/DONE -> no second transfer.
  - A second start in IDLE re-streams the identical 9 words.

Source files
------------

// File: rtl/seq_word_reader.sv
// Reader end of the 288-bit random-sequence interface: requests a sequence from the
// LFSR generator, captures it, and streams it MSB-first as 32-bit words, checking the zero pad.
module seq_word_reader #(
    parameter int SEQ_WIDTH  = 288,
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  gen_enable,
    input  logic [SEQ_WIDTH-1:0]  random_sequence,
    input  logic                  done_creating_sequence,
    output logic [WORD_WIDTH-1:0] word_out,
    output logic                  word_valid,
    input  logic                  word_ready,
    output logic                  word_last,
    output logic                  busy,
    output logic                  seq_done,
    output logic                  pad_error
);
    localparam int         NUM_WORDS  = SEQ_WIDTH / WORD_WIDTH;
    localparam logic [3:0] LAST_COUNT = 4'(NUM_WORDS - 1);

    typedef enum logic [1:0] {IDLE, REQ, SEND, DONE} state_t;

    state_t               state, next_state;
    logic [SEQ_WIDTH-1:0] shift_reg;
    logic [3:0]           count;
    logic                 capture;
    logic                 accept;

    assign capture = (state == REQ) && done_creating_sequence;
    assign accept  = word_valid && word_ready;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; the wide shift register is a plain register, so it is reset too.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_reg <= '0;
            count     <= '0;
            pad_error <= 1'b0;
        end else if (capture) begin
            shift_reg <= random_sequence;
            count     <= '0;
            pad_error <= (random_sequence[WORD_WIDTH-1:0] != '0);
        end else if (accept) begin
            shift_reg <= shift_reg << WORD_WIDTH;
            // Hold at the last index so the counter never passes the final word.
            if (count != LAST_COUNT) begin
                count <= count + 4'd1;
            end
        end
    end

    // NOTE: next_state gets its default before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start)   next_state = REQ;
            REQ:  if (capture) next_state = SEND;
            SEND: if (accept && (count == LAST_COUNT)) next_state = DONE;
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // All handshake outputs decode from registered state, so they cannot change while
    // the consumer is stalling.
    assign gen_enable = (state == REQ);
    assign word_valid = (state == SEND);
    assign word_out   = word_valid ? shift_reg[SEQ_WIDTH-1 -: WORD_WIDTH] : '0;
    assign word_last  = word_valid && (count == LAST_COUNT);
    assign busy       = (state != IDLE);
    assign seq_done   = (state == DONE);

endmodule

// File: tb/tb_seq_word_reader.sv
// Self-checking bench for seq_word_reader: table of whole transfers plus a reset-abort
// sequence, with a scoreboard comparing every accepted word against the expected stream.
module tb_seq_word_reader;
    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         gen_enable;
    logic [287:0] random_sequence;
    logic         done_creating_sequence;
    logic [31:0]  word_out;
    logic         word_valid;
    logic         word_ready;
    logic         word_last;
    logic         busy;
    logic         seq_done;
    logic         pad_error;

    seq_word_reader dut (
        .clk                    (clk),
        .reset                  (reset),
        .start                  (start),
        .gen_enable             (gen_enable),
        .random_sequence        (random_sequence),
        .done_creating_sequence (done_creating_sequence),
        .word_out               (word_out),
        .word_valid             (word_valid),
        .word_ready             (word_ready),
        .word_last              (word_last),
        .busy                   (busy),
        .seq_done               (seq_done),
        .pad_error              (pad_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [0:8][31:0] words;      // words[0] is the MSB word
        bit               pre_done;
        bit               backpressure;
        bit               poke_start;
        bit               exp_pad;
        int               exp_cycles;
    } vec_t;

    typedef struct {
        logic [31:0] word;
        bit          last;
    } exp_t;

    vec_t  vecs[5];
    exp_t  sb_q[$];
    exp_t  e;
    int    total_count  = 0;
    int    pass_count   = 0;
    int    accept_count = 0;
    bit    holding      = 1'b0;
    logic [31:0] held_word;
    logic        held_last;
    bit    pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: compare each word at the cycle it is accepted; also check stall stability.
    always @(negedge clk) begin
        if (reset && word_valid) begin
            if (holding) begin
                check("hold_word", word_out, held_word);
                check("hold_last", 32'(word_last), 32'(held_last));
            end
            if (word_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_word", word_out, 32'hxxxxxxxx);
                end else begin
                    e = sb_q.pop_front();
                    check("word", word_out, e.word);
                    check("word_last", 32'(word_last), 32'(e.last));
                    accept_count++;
                end
                holding = 1'b0;
            end else begin
                holding   = 1'b1;
                held_word = word_out;
                held_last = word_last;
            end
        end else begin
            holding = 1'b0;
        end
    end

    task automatic push_expected(input vec_t v);
        for (int i = 0; i < 9; i++) begin
            sb_q.push_back('{word: v.words[i], last: (i == 8)});
        end
    endtask

    task automatic run_transfer(input vec_t v);
        int cycles;
        int k;
        int gen_cycles;
        int acc0;
        bit seen_send;
        bit finished;
        acc0       = accept_count;
        push_expected(v);
        random_sequence        = v.words;
        done_creating_sequence = v.pre_done;
        word_ready = 1'b1;
        start      = 1'b1;
        step();
        start      = 1'b0;
        cycles     = 1;
        gen_cycles = 0;
        k          = 0;
        seen_send  = 1'b0;
        finished   = 1'b0;
        check("req_busy", 32'(busy), 32'd1);
        for (int t = 0; t < 200 && !finished; t++) begin
            if (gen_enable) gen_cycles++;
            if (word_valid && !seen_send) begin
                seen_send = 1'b1;
                check("pad_at_capture", 32'(pad_error), 32'(v.exp_pad));
            end
            if (seq_done) begin
                finished = 1'b1;
            end else begin
                if (word_valid) begin
                    word_ready = v.backpressure ? pat[k % 4] : 1'b1;
                    if (v.poke_start) start = (k == 2);
                    k++;
                end else begin
                    word_ready = 1'b1;
                end
                if (!v.pre_done && gen_enable && gen_cycles == 2) done_creating_sequence = 1'b1;
                step();
                cycles++;
            end
        end
        if (!finished) begin
            check("seq_done_timeout", 32'(seq_done), 32'd1);
        end else begin
            check("start_to_done_cycles", 32'(cycles + 1), 32'(v.exp_cycles));
            check("gen_enable_cycles", 32'(gen_cycles), v.pre_done ? 32'd1 : 32'd2);
            check("done_valid_low", 32'(word_valid), 32'd0);
            check("done_busy", 32'(busy), 32'd1);
            check("done_pad", 32'(pad_error), 32'(v.exp_pad));
            check("accepts", 32'(accept_count - acc0), 32'd9);
            check("sb_empty", 32'(sb_q.size()), 32'd0);
            if (v.poke_start) start = 1'b1;
            step();
            start = 1'b0;
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_seq_done", 32'(seq_done), 32'd0);
            check("idle_pad_held", 32'(pad_error), 32'(v.exp_pad));
            step();
            check("no_requeue_busy", 32'(busy), 32'd0);
            check("no_requeue_gen", 32'(gen_enable), 32'd0);
        end
    endtask

    task automatic reset_mid_send(input vec_t v);
        int  acc0;
        bit  got_valid;
        push_expected(v);
        random_sequence        = v.words;
        done_creating_sequence = 1'b1;
        word_ready = 1'b1;
        start      = 1'b1;
        step();
        start     = 1'b0;
        got_valid = 1'b0;
        for (int t = 0; t < 20 && !got_valid; t++) begin
            if (word_valid) got_valid = 1'b1;
            else step();
        end
        check("rst_reached_send", 32'(word_valid), 32'd1);
        acc0 = accept_count;
        repeat (3) step();
        check("rst_three_accepts", 32'(accept_count - acc0), 32'd3);
        check("rst_pad_before", 32'(pad_error), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("rst_gen_enable", 32'(gen_enable), 32'd0);
        check("rst_word_out", word_out, 32'd0);
        check("rst_word_valid", 32'(word_valid), 32'd0);
        check("rst_word_last", 32'(word_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_seq_done", 32'(seq_done), 32'd0);
        check("rst_pad_error", 32'(pad_error), 32'd0);
        sb_q.delete();
        repeat (2) step();
        #2 reset = 1'b1;
        step();
        check("rst_idle_busy", 32'(busy), 32'd0);
        check("rst_no_seq_done", 32'(seq_done), 32'd0);
    endtask

    initial begin
        vecs[0] = '{words: {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h55555555,
                            32'h66666666, 32'h77777777, 32'h88888888, 32'h00000000},
                    pre_done: 1'b0, backpressure: 1'b0, poke_start: 1'b0, exp_pad: 1'b0, exp_cycles: 13};
        vecs[1] = vecs[0];
        vecs[1].backpressure = 1'b1;
        vecs[1].exp_cycles   = 21;
        vecs[2] = '{words: {32'hA0A1A2A3, 32'hB4B5B6B7, 32'hC8C9CACB, 32'hD0D1D2D3, 32'hE4E5E6E7,
                            32'hF8F9FAFB, 32'h01234567, 32'h89ABCDEF, 32'hDEADBEEF},
                    pre_done: 1'b0, backpressure: 1'b0, poke_start: 1'b0, exp_pad: 1'b1, exp_cycles: 13};
        vecs[3] = '{words: {32'hCAFEF00D, 32'h12345678, 32'h9ABCDEF0, 32'h0F1E2D3C, 32'h4B5A6978,
                            32'h8796A5B4, 32'hC3D2E1F0, 32'h55AA55AA, 32'h00000000},
                    pre_done: 1'b1, backpressure: 1'b0, poke_start: 1'b1, exp_pad: 1'b0, exp_cycles: 12};
        vecs[4] = vecs[3];
        vecs[4].poke_start = 1'b0;

        reset                  = 1'b0;
        start                  = 1'b1;
        word_ready             = 1'b1;
        done_creating_sequence = 1'b1;
        random_sequence        = '1;
        #12;
        check("reset_gen_enable", 32'(gen_enable), 32'd0);
        check("reset_word_out", word_out, 32'd0);
        check("reset_word_valid", 32'(word_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_seq_done", 32'(seq_done), 32'd0);
        check("reset_pad_error", 32'(pad_error), 32'd0);
        start                  = 1'b0;
        done_creating_sequence = 1'b0;
        #1 reset = 1'b1;
        step();

        for (int i = 0; i < 5; i++) begin
            run_transfer(vecs[i]);
        end

        reset_mid_send(vecs[2]);
        run_transfer(vecs[0]);

        $display("%0d/%0d checks passed", pass_count, total_count);
        $finish;
    end
endmodule
